// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the ALU result checker.
package alu_pkg;

  localparam logic [2:0] OP_AVG       = 3'd0;
  localparam logic [2:0] OP_DBL       = 3'd1;
  localparam logic [2:0] OP_HALFX_ADD = 3'd2;
  localparam logic [2:0] OP_SUB_HALFY = 3'd3;
  localparam logic [2:0] OP_NAND      = 3'd4;
  localparam logic [2:0] OP_NOT       = 3'd5;
  localparam logic [2:0] OP_NOR       = 3'd6;
  localparam logic [2:0] OP_XOR       = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU: opcode plus signed operands to expected n+3 bit result.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int n = 4
) (
  input  logic [2:0]   c,
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  output logic [n+2:0] exp_o
);

  localparam int W = n + 3;
  localparam logic signed [W-1:0] TWO = W'(2);

  logic signed [W-1:0] xs, ys, sum;

  // Signed division truncates toward zero, which is the required rounding.
  always_comb begin
    xs    = {{3{x[n-1]}}, x};
    ys    = {{3{y[n-1]}}, y};
    sum   = xs + ys;
    exp_o = '0;
    case (c)
      OP_AVG:       exp_o = sum / TWO;
      OP_DBL:       exp_o = sum + sum;
      OP_HALFX_ADD: exp_o = (xs / TWO) + ys;
      OP_SUB_HALFY: exp_o = xs - (ys / TWO);
      OP_NAND:      exp_o = {3'b000, ~(x & y)};
      OP_NOT:       exp_o = {3'b000, ~x};
      OP_NOR:       exp_o = {3'b000, ~(x | y)};
      OP_XOR:       exp_o = {3'b000, x ^ y};
      default:      exp_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_result_checker.sv
// Two-stage ALU result checker with saturating pass/fail counters and halt-on-fail FSM.
// ALU_CHECKER_STICKY_ERR_EN adds capture of the first mismatching tuple.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int n  = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    C,
  input  logic [n-1:0]  X,
  input  logic [n-1:0]  Y,
  input  logic [n+2:0]  O,
  input  logic          halt_on_fail,
  input  logic          clear,
  output logic          chk_valid,
  output logic          chk_pass,
  output logic [n+2:0]  exp_O,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] fail_cnt,
  output logic          halted
`ifdef ALU_CHECKER_STICKY_ERR_EN
  ,
  output logic          err_seen,
  output logic [2:0]    err_C,
  output logic [n-1:0]  err_X,
  output logic [n-1:0]  err_Y,
  output logic [n+2:0]  err_O
`endif
);

  state_t state, state_nxt;

  logic         acc;
  logic [2:1]   vld_pipe;
  logic [2:0]   s1_c;
  logic [n-1:0] s1_x, s1_y;
  logic [n+2:0] s1_o, ref_o;

  assign in_ready  = (state == RUN) && !clear;
  assign acc       = in_valid && in_ready;
  assign chk_valid = vld_pipe[2];
  assign halted    = (state == HALT);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (chk_valid && !chk_pass && halt_on_fail) state_nxt = HALT;
      HALT:    if (clear) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) vld_pipe <= '0;
    else          vld_pipe <= {vld_pipe[1], acc};
  end

  // Stage-1 payload needs no reset: it is only consumed when vld_pipe[1] is set.
  always_ff @(posedge clk) begin
    if (acc) begin
      s1_c <= C;
      s1_x <= X;
      s1_y <= Y;
      s1_o <= O;
    end
  end

  alu_ref_model #(.n(n)) u_ref (
    .c     (s1_c),
    .x     (s1_x),
    .y     (s1_y),
    .exp_o (ref_o)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chk_pass <= 1'b0;
      exp_O    <= '0;
    end else if (vld_pipe[1]) begin
      chk_pass <= (s1_o == ref_o);
      exp_O    <= ref_o;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (chk_valid) begin
      if (chk_pass) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
      end
    end
  end

`ifdef ALU_CHECKER_STICKY_ERR_EN
  logic ref_miss;
  assign ref_miss = vld_pipe[1] && (s1_o != ref_o);

  // Captured alongside the stage-2 compare so err_seen rises with the failing chk_valid.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      err_seen <= 1'b0;
      err_C    <= '0;
      err_X    <= '0;
      err_Y    <= '0;
      err_O    <= '0;
    end else if (ref_miss && !err_seen) begin
      err_seen <= 1'b1;
      err_C    <= s1_c;
      err_X    <= s1_x;
      err_Y    <= s1_y;
      err_O    <= s1_o;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: queue-based reference model plus literal expectations.
module tb_alu_result_checker;

  localparam int CMAX = 15;

  logic       clk = 1'b0;
  logic       reset_n, in_valid, in_ready, halt_on_fail, clear;
  logic [2:0] C;
  logic [3:0] X, Y;
  logic [6:0] O, exp_O;
  logic       chk_valid, chk_pass, halted;
  logic [3:0] pass_cnt, fail_cnt;

  alu_result_checker #(.n(4), .CW(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .C(C), .X(X), .Y(Y), .O(O), .halt_on_fail(halt_on_fail), .clear(clear),
    .chk_valid(chk_valid), .chk_pass(chk_pass), .exp_O(exp_O),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .halted(halted)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;

  // Reference arithmetic on plain integers; bitwise NOT on 4 bits is 15 - v.
  function automatic logic [6:0] ref_exp(input logic [2:0] c, input logic [3:0] x, input logic [3:0] y);
    int xi, yi, r;
    xi = $signed(x);
    yi = $signed(y);
    case (c)
      3'd0: r = (xi + yi) / 2;
      3'd1: r = 2 * (xi + yi);
      3'd2: r = xi / 2 + yi;
      3'd3: r = xi - yi / 2;
      3'd4: r = 15 - int'(x & y);
      3'd5: r = 15 - int'(x);
      3'd6: r = 15 - int'(x | y);
      default: r = int'(x ^ y);
    endcase
    return r[6:0];
  endfunction

  typedef struct {
    int         due;
    logic [6:0] e;
    logic       p;
  } ent_t;

  ent_t       q[$];
  int         cur = 0;
  int         ms = 0;
  int         m_pc = 0, m_fc = 0;
  logic [6:0] m_exp = '0;
  logic       m_pass = 1'b0;

  int lit_exp[int];
  int lit_pass[int];
  int lit_pc[int];
  int lit_fc[int];
  int lit_halt[int];

  // Model: each accepted tuple becomes visible two cycles after its acceptance cycle.
  always @(posedge clk) begin
    logic       vis, accm;
    ent_t       it;
    logic [6:0] e;
    vis = 1'b0;
    if (q.size() > 0) begin
      vis = (q[0].due == cur);
      it  = q[0];
    end
    accm = reset_n && (ms == 1) && !clear && in_valid;
    if (!reset_n) begin
      q.delete();
      m_pc = 0; m_fc = 0; ms = 0; m_exp = '0; m_pass = 1'b0;
    end else begin
      if (clear) begin
        m_pc = 0; m_fc = 0;
      end else if (vis) begin
        if (it.p) m_pc = (m_pc < CMAX) ? m_pc + 1 : CMAX;
        else      m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
      end
      if (ms == 0) ms = 1;
      else if (ms == 1 && vis && !it.p && halt_on_fail) ms = 2;
      else if (ms == 2 && clear) ms = 1;
      if (vis) void'(q.pop_front());
      if (accm) begin
        e = ref_exp(C, X, Y);
        q.push_back('{cur + 2, e, (e == O)});
      end
    end
    cur++;
    if (q.size() > 0 && q[0].due == cur) begin
      m_exp  = q[0].e;
      m_pass = q[0].p;
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    nchk++;
    if (act == req) npass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cur);
  endtask

  always @(negedge clk) begin
    logic mv;
    mv = (q.size() > 0) && (q[0].due == cur);
    chk("chk_valid", int'(chk_valid), int'(mv));
    chk("chk_pass", int'(chk_pass), int'(m_pass));
    chk("exp_O", int'(exp_O), int'(m_exp));
    chk("pass_cnt", int'(pass_cnt), m_pc);
    chk("fail_cnt", int'(fail_cnt), m_fc);
    chk("halted", int'(halted), int'(ms == 2));
    chk("in_ready", int'(in_ready), int'((ms == 1) && !clear));
    if (lit_exp.exists(cur)) begin
      chk("lit_chk_valid", int'(chk_valid), 1);
      chk("lit_exp_O", int'(exp_O), lit_exp[cur]);
      chk("lit_chk_pass", int'(chk_pass), lit_pass[cur]);
    end
    if (lit_pc.exists(cur))   chk("lit_pass_cnt", int'(pass_cnt), lit_pc[cur]);
    if (lit_fc.exists(cur))   chk("lit_fail_cnt", int'(fail_cnt), lit_fc[cur]);
    if (lit_halt.exists(cur)) chk("lit_halted", int'(halted), lit_halt[cur]);
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] c, input logic [3:0] x, input logic [3:0] y,
                      input logic [6:0] o, input logic [6:0] le, input logic lp, input logic haslit);
    C = c; X = x; Y = y; O = o;
    in_valid = 1'b1;
    if (haslit) begin
      lit_exp[cur + 2]  = int'(le);
      lit_pass[cur + 2] = int'(lp);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_cnt(input int pc, input int fc);
    lit_pc[cur] = pc;
    lit_fc[cur] = fc;
  endtask

  initial begin
    int d;
    reset_n = 1'b0; in_valid = 1'b0; halt_on_fail = 1'b0; clear = 1'b0;
    C = '0; X = '0; Y = '0; O = '0;
    idle(3);
    expect_cnt(0, 0);
    lit_halt[cur] = 0;
    reset_n = 1'b1;
    idle(2);

    send(3'd0, 4'd3, 4'd5, 7'd4, 7'd4, 1'b1, 1'b1);
    idle(3);
    expect_cnt(1, 0);

    send(3'd1, 4'hD, 4'h1, 7'h7C, 7'h7C, 1'b1, 1'b1);
    send(3'd2, 4'hD, 4'h2, 7'h01, 7'h01, 1'b1, 1'b1);
    send(3'd4, 4'hC, 4'hA, 7'h07, 7'h07, 1'b1, 1'b1);
    send(3'd3, 4'h5, 4'h3, 7'h04, 7'h04, 1'b1, 1'b1);
    send(3'd5, 4'h2, 4'h0, 7'h00, 7'h0D, 1'b0, 1'b1);
    send(3'd6, 4'h1, 4'h2, 7'h0C, 7'h0C, 1'b1, 1'b1);
    send(3'd0, 4'hD, 4'h0, 7'h7F, 7'h7F, 1'b1, 1'b1);
    send(3'd3, 4'h8, 4'hF, 7'h78, 7'h78, 1'b1, 1'b1);
    send(3'd2, 4'hF, 4'h0, 7'h00, 7'h00, 1'b1, 1'b1);
    idle(3);
    expect_cnt(9, 1);

    // Halt on a mismatch; the tuple behind it still completes and is counted.
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    halt_on_fail = 1'b1;
    d = cur + 2;
    send(3'd7, 4'h5, 4'h3, 7'h00, 7'h06, 1'b0, 1'b1);
    send(3'd7, 4'h1, 4'h1, 7'h00, 7'h00, 1'b1, 1'b1);
    lit_halt[d + 1] = 1;
    lit_fc[d + 1]   = 1;
    lit_pc[d + 2]   = 1;
    idle(1);
    C = 3'd0; X = 4'h1; Y = 4'h1; O = 7'h01;
    in_valid = 1'b1;
    idle(3);
    in_valid = 1'b0;
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    expect_cnt(0, 0);
    lit_halt[cur] = 0;

    // Clear coinciding with a result drops it from the count.
    halt_on_fail = 1'b0;
    send(3'd0, 4'h1, 4'h1, 7'h01, 7'h01, 1'b1, 1'b1);
    send(3'd0, 4'h2, 4'h2, 7'h02, 7'h02, 1'b1, 1'b1);
    idle(1);
    expect_cnt(1, 0);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    expect_cnt(0, 0);

    for (int i = 0; i < 17; i++) send(3'd7, i[3:0], 4'h0, {3'b000, i[3:0]}, 7'h00, 1'b0, 1'b0);
    idle(3);
    expect_cnt(CMAX, 0);

    // Reset lands in the middle of a back-to-back stream.
    for (int i = 0; i < 8; i++) begin
      if (i == 3) reset_n = 1'b0;
      send(3'd1, i[3:0], 4'h1, 7'h00, 7'h00, 1'b0, 1'b0);
    end
    idle(1);
    expect_cnt(0, 0);
    lit_halt[cur] = 0;
    reset_n = 1'b1;
    idle(4);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
